cam_writer: RTL and testbench

CAM_WRITER -- requirements
Module: cam_writer

---
 rtl/cam_pkg.sv | 25 ++
 rtl/HammingWeight_8bit.sv | 15 +
 rtl/cam_writer.sv | 178 +++++++++++++++++
 tb/tb_cam_writer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants and enumerations for the CAM writer.
package cam_pkg;

  localparam int unsigned CAM_DEPTH = 8;
  localparam int unsigned CAM_WIDTH = 16;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_DELETE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_MISS_DUP = 2'b01,
    ST_FULL     = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCommit,
    StResp
  } state_e;

endpackage

// File: rtl/HammingWeight_8bit.sv
// Population count of an 8-bit vector.
module HammingWeight_8bit (
  input  logic [7:0] vec,
  output logic [3:0] weight
);

  // Sum the set bits.
  always_comb begin
    weight = '0;
    for (int i = 0; i < 8; i++) begin
      weight = weight + {3'b000, vec[i]};
    end
  end

endmodule

// File: rtl/cam_writer.sv
// CAM writer: serialised insert/delete of keys into an 8-entry CAM.
// Each request scans all entries (one per cycle), commits, then pulses done.
// Optional build macro CAM_WRITER_PRESET_EN: reset loads entry i with value i
// and marks all entries valid; otherwise reset clears everything.
module cam_writer
  import cam_pkg::*;
#(
  parameter int unsigned DEPTH = CAM_DEPTH,
  parameter int unsigned WIDTH = CAM_WIDTH
) (
  input  logic                     clk,
  input  logic                     init_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     wr_op,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     done,
  output logic [2:0]               done_addr,
  output logic [1:0]               done_status,
  output logic [DEPTH*WIDTH-1:0]   entry_data,
  output logic [DEPTH-1:0]         entry_vld,
  output logic [3:0]               occupancy
);

  localparam int unsigned AW = 3;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             hit_q, hit_d;
  logic [AW-1:0]    hit_idx_q, hit_idx_d;
  logic             free_q, free_d;
  logic [AW-1:0]    free_idx_q, free_idx_d;
  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    done_addr_q, done_addr_d;
  status_e          status_q, status_d;

  // Next-state, scan bookkeeping, commit and handshake outputs.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    free_d      = free_q;
    free_idx_d  = free_idx_q;
    entries_d   = entries_q;
    vld_d       = vld_q;
    done_addr_d = done_addr_q;
    status_d    = status_q;
    wr_ready    = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          op_d       = op_e'(wr_op);
          key_d      = wr_data;
          idx_d      = '0;
          hit_d      = 1'b0;
          hit_idx_d  = '0;
          free_d     = 1'b0;
          free_idx_d = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        // First hit wins, so the recorded indices are the lowest ones.
        if (vld_q[idx_q] && (entries_q[idx_q] == key_q) && !hit_q) begin
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
        end
        if (!vld_q[idx_q] && !free_q) begin
          free_d     = 1'b1;
          free_idx_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        state_d     = StResp;
        done_addr_d = '0;
        if (op_q == OP_INSERT) begin
          if (hit_q) begin
            status_d    = ST_MISS_DUP;
            done_addr_d = hit_idx_q;
          end else if (!free_q) begin
            status_d = ST_FULL;
          end else begin
            entries_d[free_idx_q] = key_q;
            vld_d[free_idx_q]     = 1'b1;
            status_d              = ST_OK;
            done_addr_d           = free_idx_q;
          end
        end else begin
          if (hit_q) begin
            // Data is left in place; only the valid bit drops.
            vld_d[hit_idx_q] = 1'b0;
            status_d         = ST_OK;
            done_addr_d      = hit_idx_q;
          end else begin
            status_d = ST_MISS_DUP;
          end
        end
      end
      StResp: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q     <= StIdle;
      op_q        <= OP_INSERT;
      key_q       <= '0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      free_q      <= 1'b0;
      free_idx_q  <= '0;
      done_addr_q <= '0;
      status_q    <= ST_OK;
`ifdef CAM_WRITER_PRESET_EN
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= WIDTH'(i);
      end
      vld_q <= '1;
`else
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      vld_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      free_q      <= free_d;
      free_idx_q  <= free_idx_d;
      done_addr_q <= done_addr_d;
      status_q    <= status_d;
      entries_q   <= entries_d;
      vld_q       <= vld_d;
    end
  end

  // Flatten the entry array for the lookup side.
  always_comb begin
    entry_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_data[i*WIDTH +: WIDTH] = entries_q[i];
    end
  end

  assign entry_vld   = vld_q;
  assign done_addr   = done_addr_q;
  assign done_status = status_q;

  HammingWeight_8bit u_popcount (
    .vec    (vld_q),
    .weight (occupancy)
  );

endmodule

// File: tb/tb_cam_writer.sv
// Directed self-checking bench for cam_writer.
module tb_cam_writer;

  logic         clk;
  logic         init_n;
  logic         wr_valid;
  logic         wr_ready;
  logic         wr_op;
  logic [15:0]  wr_data;
  logic         done;
  logic [2:0]   done_addr;
  logic [1:0]   done_status;
  logic [127:0] entry_data;
  logic [7:0]   entry_vld;
  logic [3:0]   occupancy;

  int n_checks = 0;
  int n_errors = 0;

  cam_writer dut (
    .clk         (clk),
    .init_n      (init_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_op       (wr_op),
    .wr_data     (wr_data),
    .done        (done),
    .done_addr   (done_addr),
    .done_status (done_status),
    .entry_data  (entry_data),
    .entry_vld   (entry_vld),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ent(input int i);
    return entry_data[i*16 +: 16];
  endfunction

  // One request: handshake, verify latency and response, then ready returns.
  task automatic do_op(input string tag, input logic op, input logic [15:0] key,
                       input logic [1:0] exp_st, input logic [2:0] exp_addr);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b1;
    wr_op    = op;
    wr_data  = key;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_data  = ~key;  // must not disturb the latched key
    check({tag, " busy"}, wr_ready, 1'b0);
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check({tag, " latency"}, n, 9);
    check({tag, " status"}, done_status, exp_st);
    check({tag, " addr"}, done_addr, exp_addr);
    @(posedge clk);
    #1;
    check({tag, " ready back"}, {wr_ready, done}, 2'b10);
  endtask

  task automatic do_reset();
    init_n = 1'b0;
    #1;
    check("rst ready", wr_ready, 1'b1);
    check("rst done", {done, done_addr, done_status}, 6'b0);
    @(negedge clk);
    init_n = 1'b1;
  endtask

  // Abort a request mid-scan; no done pulse may follow.
  task automatic mid_scan_reset(input logic [7:0] exp_vld, input logic [3:0] exp_occ);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_op    = 1'b0;
    wr_data  = 16'h7777;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    init_n = 1'b0;
    #1;
    check("abort ready", wr_ready, 1'b1);
    check("abort vld", entry_vld, exp_vld);
    check("abort occ", occupancy, exp_occ);
    @(negedge clk);
    init_n = 1'b1;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("abort no done", seen, 1'b0);
  endtask

  initial begin
    init_n   = 1'b1;
    wr_valid = 1'b0;
    wr_op    = 1'b0;
    wr_data  = '0;
    #2;
    do_reset();
`ifdef CAM_WRITER_PRESET_EN
    check("preset vld", entry_vld, 8'hFF);
    check("preset occ", occupancy, 4'd8);
    check("preset e5", ent(5), 16'h0005);
    do_op("del 5", 1'b1, 16'h0005, 2'b00, 3'd5);
    check("del 5 occ", occupancy, 4'd7);
    check("del 5 vld", entry_vld, 8'hDF);
    check("del 5 data kept", ent(5), 16'h0005);
    do_op("ins full", 1'b0, 16'h0009, 2'b00, 3'd5);
    check("ins e5", ent(5), 16'h0009);
    mid_scan_reset(8'hFF, 4'd8);
    check("abort e5", ent(5), 16'h0005);
`else
    check("rst vld", entry_vld, 8'h00);
    check("rst occ", occupancy, 4'd0);
    check("rst data", entry_data, 128'h0);
    do_op("ins beef", 1'b0, 16'hBEEF, 2'b00, 3'd0);
    check("ins beef vld", entry_vld, 8'h01);
    check("ins beef occ", occupancy, 4'd1);
    check("ins beef e0", ent(0), 16'hBEEF);
    do_op("dup beef", 1'b0, 16'hBEEF, 2'b01, 3'd0);
    check("dup vld", entry_vld, 8'h01);
    check("dup e1", ent(1), 16'h0000);
    for (int i = 1; i < 8; i++) begin
      do_op($sformatf("fill %0d", i), 1'b0, 16'h1000 + 16'(i), 2'b00, 3'(i));
    end
    check("fill vld", entry_vld, 8'hFF);
    check("fill occ", occupancy, 4'd8);
    check("fill e7", ent(7), 16'h1007);
    do_op("ins full", 1'b0, 16'h1234, 2'b10, 3'd0);
    check("full occ", occupancy, 4'd8);
    do_op("del s3", 1'b1, 16'h1003, 2'b00, 3'd3);
    check("del s3 vld", entry_vld, 8'hF7);
    check("del s3 occ", occupancy, 4'd7);
    check("del s3 data kept", ent(3), 16'h1003);
    do_op("ins aaaa", 1'b0, 16'hAAAA, 2'b00, 3'd3);
    check("ins aaaa e3", ent(3), 16'hAAAA);
    check("ins aaaa vld", entry_vld, 8'hFF);
    do_op("del absent", 1'b1, 16'h5555, 2'b01, 3'd0);
    check("del absent vld", entry_vld, 8'hFF);
    do_op("del beef", 1'b1, 16'hBEEF, 2'b00, 3'd0);
    check("del beef vld", entry_vld, 8'hFE);
    // Stale data in an invalid slot must not match.
    do_op("del beef again", 1'b1, 16'hBEEF, 2'b01, 3'd0);
    do_op("reins beef", 1'b0, 16'hBEEF, 2'b00, 3'd0);
    check("reins occ", occupancy, 4'd8);
    mid_scan_reset(8'h00, 4'd0);
    check("abort data", entry_data, 128'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
